// File: rtl/divider_pkg.sv
// Shared state encoding and constants for the eight-lane histogram-equalisation divider.
package divider_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      DIVIDE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int ITER  = 40;
   localparam int SCALE = 255;
   localparam int LANES = 8;
endpackage

// File: rtl/div_lane_restoring.sv
// One restoring-division lane: computes ((cdf - cdf_min) * 255) / (total - cdf_min),
// one quotient bit per step; the numerator register doubles as the quotient register.
module div_lane_restoring #(
   parameter int CDF_W = 32
) (
   input  logic                   clk,
   input  logic                   load,
   input  logic                   step,
   input  logic [CDF_W-1:0]       cdf,
   input  logic [CDF_W-1:0]       cdf_min,
   input  logic [CDF_W-1:0]       total_pixels,
   output logic [39:0]            quotient,
   output logic                   zero_den
);
   import divider_pkg::*;

   logic [ITER-1:0]         num_p1;
   logic [CDF_W:0]          rem_p1;
   logic [CDF_W-1:0]        den_p1;
   logic                    zero_den_p1;

   logic [CDF_W-1:0]        diff;
   logic [ITER-1:0]         diff_ext;
   logic [ITER-1:0]         num_ld;
   logic [CDF_W:0]          rem_sh;
   logic signed [CDF_W+2:0] trial;

   always_comb begin
      diff     = cdf - cdf_min;
      diff_ext = {{(ITER-CDF_W){1'b0}}, diff};
      // x*255 as (x<<8) - x keeps the scaling to one subtractor
      num_ld   = (cdf >= cdf_min) ? ((diff_ext << 8) - diff_ext) : '0;
      rem_sh   = {rem_p1[CDF_W-1:0], num_p1[ITER-1]};
      trial    = $signed({2'b00, rem_sh}) - $signed({3'b000, den_p1});
   end

   // ---- load / iterate stage ----
   always_ff @(posedge clk) begin
      if (load) begin
         num_p1      <= num_ld;
         rem_p1      <= '0;
         den_p1      <= total_pixels - cdf_min;
         zero_den_p1 <= (total_pixels <= cdf_min);
      end else if (step) begin
         if (trial >= 0) begin
            rem_p1 <= trial[CDF_W:0];
            num_p1 <= {num_p1[ITER-2:0], 1'b1};
         end else begin
            rem_p1 <= rem_sh;
            num_p1 <= {num_p1[ITER-2:0], 1'b0};
         end
      end
   end

   assign quotient = num_p1;
   assign zero_den = zero_den_p1;
endmodule

// File: rtl/divider_lane_array.sv
// Eight lock-step restoring dividers producing histogram-equalised 8-bit levels,
// delivered as one packed 64-bit word with a single-cycle valid strobe.
module divider_lane_array #(
   parameter int LANES = 8,
   parameter int CDF_W = 32,
   parameter int OUT_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [CDF_W-1:0]       cdfval_todiv1,
   input  logic [CDF_W-1:0]       cdfval_todiv2,
   input  logic [CDF_W-1:0]       cdfval_todiv3,
   input  logic [CDF_W-1:0]       cdfval_todiv4,
   input  logic [CDF_W-1:0]       cdfval_todiv5,
   input  logic [CDF_W-1:0]       cdfval_todiv6,
   input  logic [CDF_W-1:0]       cdfval_todiv7,
   input  logic [CDF_W-1:0]       cdfval_todiv8,
   input  logic [CDF_W-1:0]       cdf_min,
   input  logic [CDF_W-1:0]       total_pixels,
   output logic                   busy,
   output logic                   eq_valid,
   output logic [LANES*OUT_W-1:0] eq_data
);
   import divider_pkg::*;

   state_t                  state_q, state_d;
   logic [5:0]              cnt_p1;
   logic [CDF_W-1:0]        cdf_in [LANES];
   logic [CDF_W-1:0]        cdf_p0 [LANES];
   logic [CDF_W-1:0]        cdf_min_p0;
   logic [CDF_W-1:0]        total_p0;
   logic [39:0]             quo [LANES];
   logic                    zd [LANES];
   logic [LANES*OUT_W-1:0]  packed_lv;
   logic [LANES*OUT_W-1:0]  eq_data_p2;
   logic                    accept;

   function automatic logic [OUT_W-1:0] sat_level(input logic [39:0] q, input logic zero);
      if (zero)
         return '0;
      else if (q > 40'(SCALE))
         return OUT_W'(SCALE);
      else
         return q[OUT_W-1:0];
   endfunction

   assign cdf_in[0] = cdfval_todiv1;
   assign cdf_in[1] = cdfval_todiv2;
   assign cdf_in[2] = cdfval_todiv3;
   assign cdf_in[3] = cdfval_todiv4;
   assign cdf_in[4] = cdfval_todiv5;
   assign cdf_in[5] = cdfval_todiv6;
   assign cdf_in[6] = cdfval_todiv7;
   assign cdf_in[7] = cdfval_todiv8;

   assign accept = (state_q == IDLE) && start;

   // ---- operand capture stage ----
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < LANES; k++) cdf_p0[k] <= cdf_in[k];
         cdf_min_p0 <= cdf_min;
         total_p0   <= total_pixels;
      end
   end

   // ---- divide stage ----
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      div_lane_restoring #(.CDF_W(CDF_W)) u_lane (
         .clk          (clk),
         .load         (state_q == LOAD),
         .step         (state_q == DIVIDE),
         .cdf          (cdf_p0[k]),
         .cdf_min      (cdf_min_p0),
         .total_pixels (total_p0),
         .quotient     (quo[k]),
         .zero_den     (zd[k])
      );
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_p1  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == LOAD)
            cnt_p1 <= '0;
         else if (state_q == DIVIDE)
            cnt_p1 <= cnt_p1 + 6'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = LOAD;
         LOAD:    state_d = DIVIDE;
         DIVIDE:  if (cnt_p1 == 6'(ITER-1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---- output packing stage ----
   always_comb begin
      packed_lv = '0;
      for (int k = 0; k < LANES; k++)
         packed_lv[k*OUT_W +: OUT_W] = sat_level(quo[k], zd[k]);
   end

   // The DONE cycle shows the fresh quotients directly; the register keeps them afterwards.
   always_ff @(posedge clk) begin
      if (!reset)
         eq_data_p2 <= '0;
      else if (state_q == DONE)
         eq_data_p2 <= packed_lv;
   end

   assign busy     = (state_q != IDLE);
   assign eq_valid = (state_q == DONE);
   assign eq_data  = (state_q == DONE) ? packed_lv : eq_data_p2;
endmodule
